calc_entry_ctrl: RTL and testbench

- Consumes the 5-bit key code from the grid cursor when the user presses "select", as a single-cycle key_valid pulse from the button conditioning logic.
- Assembles hex operand A, the operator and operand B, then evaluates the result on EXE.
- Drives the value shown on the 7-segment/VGA display.
- Owns the calculator entry state machine, including CE/CLR handling and result chaining.

---
 rtl/calc_entry_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// calc_entry_ctrl
//   Calculator entry controller. Consumes key presses from the grid cursor,
//   assembles hex operand A, an operator and operand B, evaluates on EXE and
//   supports chaining a result into a new calculation.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high (dominates key_valid)
//   key_valid     one-cycle pulse, key_code sampled on this cycle
//   key_code      0x00-0x0F digit, 0x10 add, 0x11 mult, 0x12 and, 0x13 EXE,
//                 0x14 sub, 0x15 or, 0x16 CE, 0x17 CLR, others ignored
//   display       registered value to show
//   state         0=ENTER_A, 1=ENTER_B, 2=SHOW_RES
//   opcode        latched operator: 0 add, 1 sub, 2 mult, 3 and, 4 or
//   result_valid  one-cycle pulse when a result is loaded
//   overflow      flag for the last evaluated result
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ENTER_A   | collecting digits of operand A
// ENTER_B   | operator latched, collecting digits of operand B
// SHOW_RES  | result displayed; digit starts over, operator chains result
// ---------------------------------------------------------------------------
module calc_entry_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [4:0]       key_code,
    output logic [WIDTH-1:0] display,
    output logic [1:0]       state,
    output logic [2:0]       opcode,
    output logic             result_valid,
    output logic             overflow
);

    localparam int MAX_DIGITS = WIDTH / 4;
    localparam int CW         = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
        $error("calc_entry_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'd0,
        ST_ENTER_B  = 2'd1,
        ST_SHOW_RES = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_a_q, acc_a_d;
    logic [WIDTH-1:0]  acc_b_q, acc_b_d;
    logic [CW-1:0]     cnt_a_q, cnt_a_d;
    logic [CW-1:0]     cnt_b_q, cnt_b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [2:0]        opcode_q, opcode_d;
    logic              result_valid_q, result_valid_d;
    logic              overflow_q, overflow_d;
    logic [WIDTH-1:0]  display_q, display_d;

    // key decode
    logic       is_digit, is_op, is_exe, is_ce, is_clr;
    logic [2:0] op_sel;
    logic [3:0] digit;

    assign digit    = key_code[3:0];
    assign is_digit = ~key_code[4];
    assign is_exe   = (key_code == 5'h13);
    assign is_ce    = (key_code == 5'h16);
    assign is_clr   = (key_code == 5'h17);

    always_comb begin
        is_op  = 1'b1;
        op_sel = OP_ADD;
        unique case (key_code)
            5'h10:   op_sel = OP_ADD;
            5'h11:   op_sel = OP_MUL;
            5'h12:   op_sel = OP_AND;
            5'h14:   op_sel = OP_SUB;
            5'h15:   op_sel = OP_OR;
            default: is_op  = 1'b0;
        endcase
    end

    // arithmetic on the current operands, used only when EXE is accepted
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ov;

    assign sum_w  = {1'b0, acc_a_q} + {1'b0, acc_b_q};
    assign prod_w = {{WIDTH{1'b0}}, acc_a_q} * {{WIDTH{1'b0}}, acc_b_q};

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        unique case (opcode_q)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_ov  = sum_w[WIDTH];
            end
            OP_SUB: begin
                alu_res = acc_a_q - acc_b_q;
                alu_ov  = (acc_a_q < acc_b_q);
            end
            OP_MUL: begin
                alu_res = prod_w[WIDTH-1:0];
                alu_ov  = |prod_w[2*WIDTH-1:WIDTH];
            end
            OP_AND:  alu_res = acc_a_q & acc_b_q;
            OP_OR:   alu_res = acc_a_q | acc_b_q;
            default: alu_res = '0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ENTER_A;
            acc_a_q        <= '0;
            acc_b_q        <= '0;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            result_q       <= '0;
            opcode_q       <= OP_ADD;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            display_q      <= '0;
        end else begin
            state_q        <= state_d;
            acc_a_q        <= acc_a_d;
            acc_b_q        <= acc_b_d;
            cnt_a_q        <= cnt_a_d;
            cnt_b_q        <= cnt_b_d;
            result_q       <= result_d;
            opcode_q       <= opcode_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            display_q      <= display_d;
        end
    end

    // next-state
    always_comb begin
        state_d        = state_q;
        acc_a_d        = acc_a_q;
        acc_b_d        = acc_b_q;
        cnt_a_d        = cnt_a_q;
        cnt_b_d        = cnt_b_q;
        result_d       = result_q;
        opcode_d       = opcode_q;
        overflow_d     = overflow_q;
        result_valid_d = 1'b0;

        if (key_valid) begin
            // CE while a result is shown has nothing partial to clear, so it acts as CLR
            if (is_clr || (is_ce && state_q == ST_SHOW_RES)) begin
                state_d    = ST_ENTER_A;
                acc_a_d    = '0;
                acc_b_d    = '0;
                cnt_a_d    = '0;
                cnt_b_d    = '0;
                result_d   = '0;
                opcode_d   = OP_ADD;
                overflow_d = 1'b0;
            end else begin
                unique case (state_q)
                    ST_ENTER_A: begin
                        if (is_digit) begin
                            if (cnt_a_q < CNT_MAX) begin
                                acc_a_d = {acc_a_q[WIDTH-5:0], digit};
                                cnt_a_d = cnt_a_q + 1'b1;
                            end
                        end else if (is_op) begin
                            opcode_d = op_sel;
                            acc_b_d  = '0;
                            cnt_b_d  = '0;
                            state_d  = ST_ENTER_B;
                        end else if (is_ce) begin
                            acc_a_d = '0;
                            cnt_a_d = '0;
                        end
                    end
                    ST_ENTER_B: begin
                        if (is_digit) begin
                            if (cnt_b_q < CNT_MAX) begin
                                acc_b_d = {acc_b_q[WIDTH-5:0], digit};
                                cnt_b_d = cnt_b_q + 1'b1;
                            end
                        end else if (is_op) begin
                            // operator can only be changed before B has digits
                            if (cnt_b_q == '0) opcode_d = op_sel;
                        end else if (is_exe) begin
                            if (cnt_b_q != '0) begin
                                result_d       = alu_res;
                                overflow_d     = alu_ov;
                                result_valid_d = 1'b1;
                                state_d        = ST_SHOW_RES;
                            end
                        end else if (is_ce) begin
                            acc_b_d = '0;
                            cnt_b_d = '0;
                        end
                    end
                    ST_SHOW_RES: begin
                        if (is_digit) begin
                            acc_a_d = {{(WIDTH-4){1'b0}}, digit};
                            cnt_a_d = CW'(1);
                            state_d = ST_ENTER_A;
                        end else if (is_op) begin
                            // chained result is treated as a full operand: no more digits
                            acc_a_d  = result_q;
                            cnt_a_d  = CNT_MAX;
                            opcode_d = op_sel;
                            acc_b_d  = '0;
                            cnt_b_d  = '0;
                            state_d  = ST_ENTER_B;
                        end
                    end
                    default: state_d = ST_ENTER_A;
                endcase
            end
        end
    end

    // outputs: display follows the post-edge state
    always_comb begin
        display_d = acc_a_d;
        unique case (state_d)
            ST_ENTER_A:  display_d = acc_a_d;
            ST_ENTER_B:  display_d = (cnt_b_d != '0) ? acc_b_d : acc_a_d;
            ST_SHOW_RES: display_d = result_d;
            default:     display_d = acc_a_d;
        endcase
    end

    assign display      = display_q;
    assign state        = state_q;
    assign opcode       = opcode_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;

    localparam int    W    = 16;
    localparam int    MAXD = W / 4;
    localparam longint MODV = longint'(1) << W;

    localparam logic [4:0] K_ADD = 5'h10, K_MUL = 5'h11, K_AND = 5'h12, K_EXE = 5'h13;
    localparam logic [4:0] K_SUB = 5'h14, K_OR  = 5'h15, K_CE  = 5'h16, K_CLR = 5'h17;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [4:0]   key_code;
    logic [W-1:0] display;
    logic [1:0]   state;
    logic [2:0]   opcode;
    logic         result_valid;
    logic         overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    calc_entry_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .display      (display),
        .state        (state),
        .opcode       (opcode),
        .result_valid (result_valid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // behavioural reference model
    int     m_state;
    longint m_a, m_b, m_res;
    int     m_ca, m_cb, m_op;
    bit     m_ov, m_rv;

    function automatic void model_reset();
        m_state = 0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0;
        m_res = 0; m_op = 0; m_ov = 0; m_rv = 0;
    endfunction

    function automatic void model_key(input logic [4:0] k);
        int opv;
        longint r;
        m_rv = 0;
        opv = -1;
        case (k)
            K_ADD: opv = 0;
            K_SUB: opv = 1;
            K_MUL: opv = 2;
            K_AND: opv = 3;
            K_OR:  opv = 4;
            default: opv = -1;
        endcase
        if (k == K_CLR || (k == K_CE && m_state == 2)) begin
            model_reset();
        end else if (k < 16) begin
            if (m_state == 0) begin
                if (m_ca < MAXD) begin m_a = (m_a * 16 + k) % MODV; m_ca++; end
            end else if (m_state == 1) begin
                if (m_cb < MAXD) begin m_b = (m_b * 16 + k) % MODV; m_cb++; end
            end else begin
                m_a = k; m_ca = 1; m_state = 0;
            end
        end else if (opv >= 0) begin
            if (m_state == 0) begin
                m_op = opv; m_b = 0; m_cb = 0; m_state = 1;
            end else if (m_state == 1) begin
                if (m_cb == 0) m_op = opv;
            end else begin
                m_a = m_res; m_ca = MAXD; m_op = opv; m_b = 0; m_cb = 0; m_state = 1;
            end
        end else if (k == K_EXE) begin
            if (m_state == 1 && m_cb > 0) begin
                case (m_op)
                    0: begin r = m_a + m_b; m_ov = (r >= MODV); end
                    1: begin r = m_a - m_b + MODV; m_ov = (m_a < m_b); end
                    2: begin r = m_a * m_b; m_ov = (r >= MODV); end
                    3: begin r = m_a & m_b; m_ov = 0; end
                    default: begin r = m_a | m_b; m_ov = 0; end
                endcase
                m_res = r % MODV;
                m_rv = 1;
                m_state = 2;
            end
        end else if (k == K_CE) begin
            if (m_state == 0) begin m_a = 0; m_ca = 0; end
            else begin m_b = 0; m_cb = 0; end
        end
    endfunction

    function automatic logic [W-1:0] model_disp();
        if (m_state == 0) return W'(m_a);
        if (m_state == 1) return (m_cb > 0) ? W'(m_b) : W'(m_a);
        return W'(m_res);
    endfunction

    // drive one key pulse starting at a negedge; returns at the next negedge
    task automatic press(input logic [4:0] k);
        key_valid = 1'b1;
        key_code  = k;
        model_key(k);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 5'h1F;
    endtask

    task automatic idle();
        key_valid = 1'b0;
        @(negedge clk);
        m_rv = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key_code = 5'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        total_cnt++;
        if ({display, state, opcode, result_valid, overflow} !== '0) begin
            $display("FAIL reset: disp=%h st=%0d op=%0d rv=%b ov=%b, required all zero",
                     display, state, opcode, result_valid, overflow);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        press(5'h1); press(5'h2);
        total_cnt++;
        if (display !== 16'h0012) $display("FAIL basic_after_2: got %h required 0012", display);
        else pass_cnt++;
        press(K_ADD);
        total_cnt++;
        if (display !== 16'h0012 || state !== 2'd1)
            $display("FAIL basic_after_add: got disp=%h st=%0d required 0012/1", display, state);
        else pass_cnt++;
        press(5'h3); press(5'h4);
        total_cnt++;
        if (display !== 16'h0034) $display("FAIL basic_after_4: got %h required 0034", display);
        else pass_cnt++;
        press(K_EXE);
        total_cnt++;
        if (display !== 16'h0046 || result_valid !== 1'b1 || state !== 2'd2 || overflow !== 1'b0)
            $display("FAIL basic_exe: got disp=%h rv=%b st=%0d ov=%b required 0046/1/2/0",
                     display, result_valid, state, overflow);
        else pass_cnt++;
        idle();
        total_cnt++;
        if (result_valid !== 1'b0) $display("FAIL basic_rv_pulse: got %b required 0", result_valid);
        else pass_cnt++;
    endtask

    task automatic test_digit_limit();
        press(K_CLR);
        repeat (5) press(5'hF);
        total_cnt++;
        if (display !== 16'hFFFF) $display("FAIL limit_fifth_digit: got %h required FFFF", display);
        else pass_cnt++;
        press(K_ADD); press(5'h1); press(K_EXE);
        total_cnt++;
        if (display !== 16'h0000 || overflow !== 1'b1)
            $display("FAIL limit_add_carry: got disp=%h ov=%b required 0000/1", display, overflow);
        else pass_cnt++;
    endtask

    task automatic test_sub_chain();
        press(K_CLR);
        press(5'h5); press(K_SUB); press(5'h7); press(K_EXE);
        total_cnt++;
        if (display !== 16'hFFFE || overflow !== 1'b1 || opcode !== 3'd1)
            $display("FAIL sub_borrow: got disp=%h ov=%b op=%0d required FFFE/1/1", display, overflow, opcode);
        else pass_cnt++;
        press(K_MUL);
        total_cnt++;
        if (display !== 16'hFFFE || state !== 2'd1)
            $display("FAIL chain_op: got disp=%h st=%0d required FFFE/1", display, state);
        else pass_cnt++;
        press(5'h3); press(K_EXE);
        total_cnt++;
        if (display !== 16'hFFFA || overflow !== 1'b1)
            $display("FAIL chain_mult: got disp=%h ov=%b required FFFA/1", display, overflow);
        else pass_cnt++;
        press(5'h9);
        total_cnt++;
        if (state !== 2'd0 || display !== 16'h0009 || overflow !== 1'b1)
            $display("FAIL chain_digit: got st=%0d disp=%h ov=%b required 0/0009/1", state, display, overflow);
        else pass_cnt++;
    endtask

    task automatic test_opreplace_ce();
        press(K_CLR);
        press(5'h8); press(K_ADD); press(K_OR);
        total_cnt++;
        if (opcode !== 3'd4) $display("FAIL op_replace: got %0d required 4", opcode);
        else pass_cnt++;
        press(5'h2); press(K_SUB);
        total_cnt++;
        if (opcode !== 3'd4) $display("FAIL op_after_digit: got %0d required 4", opcode);
        else pass_cnt++;
        press(K_EXE);
        total_cnt++;
        if (display !== 16'h000A) $display("FAIL or_result: got %h required 000A", display);
        else pass_cnt++;
        press(5'h4); press(K_SUB); press(5'h3); press(K_CE);
        total_cnt++;
        if (display !== 16'h0004 || opcode !== 3'd1)
            $display("FAIL ce_b: got disp=%h op=%0d required 0004/1", display, opcode);
        else pass_cnt++;
        press(5'h1); press(K_EXE);
        total_cnt++;
        if (display !== 16'h0003 || overflow !== 1'b0)
            $display("FAIL ce_result: got disp=%h ov=%b required 0003/0", display, overflow);
        else pass_cnt++;
    endtask

    task automatic test_rst_priority();
        press(5'h6); // leave a non-zero value in A
        rst = 1'b1; key_valid = 1'b1; key_code = 5'h7;
        @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        model_reset();
        total_cnt++;
        if ({display, state, opcode, result_valid, overflow} !== '0)
            $display("FAIL rst_over_key: disp=%h st=%0d op=%0d rv=%b ov=%b required all zero",
                     display, state, opcode, result_valid, overflow);
        else pass_cnt++;
    endtask

    task automatic test_invalid();
        press(5'hA); press(5'hB);
        press(5'h1F); press(K_EXE); press(5'h18);
        total_cnt++;
        if (display !== 16'h00AB || state !== 2'd0)
            $display("FAIL invalid_ignored: got disp=%h st=%0d required 00AB/0", display, state);
        else pass_cnt++;
    endtask

    task automatic test_clr();
        press(K_MUL); press(5'h5); press(K_CLR);
        total_cnt++;
        if (state !== 2'd0 || display !== 16'h0000 || opcode !== 3'd0)
            $display("FAIL clr_in_b: got st=%0d disp=%h op=%0d required 0/0000/0", state, display, opcode);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [4:0]   k;
        logic [W-1:0] ed;
        int           r;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            r = $urandom_range(0, 99);
            if (r < 45)      k = ($urandom_range(0, 3) == 0) ? 5'hF : 5'($urandom_range(0, 15));
            else if (r < 70) begin
                case ($urandom_range(0, 4))
                    0: k = K_ADD; 1: k = K_SUB; 2: k = K_MUL; 3: k = K_AND; default: k = K_OR;
                endcase
            end
            else if (r < 84) k = K_EXE;
            else if (r < 90) k = K_CE;
            else if (r < 93) k = K_CLR;
            else             k = 5'($urandom_range(24, 31));
            press(k);
            ed = model_disp();
            total_cnt++;
            if (display !== ed || state !== 2'(m_state) || opcode !== 3'(m_op) ||
                result_valid !== m_rv || overflow !== m_ov) begin
                $display("FAIL rand[%0d] key=%h: got disp=%h st=%0d op=%0d rv=%b ov=%b required %h/%0d/%0d/%b/%b",
                         i, k, display, state, opcode, result_valid, overflow,
                         ed, m_state, m_op, m_rv, m_ov);
            end else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digit_limit();
        test_sub_chain();
        test_opreplace_ce();
        test_rst_priority();
        test_invalid();
        test_clr();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
